// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode/funct3 encodings, ALU operation enum, and the
// control_info decode struct used by the datapath and by the top level.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_B    = 3'd0;
    localparam logic [2:0] F3_H    = 3'd1;
    localparam logic [2:0] F3_BU   = 3'd4;
    localparam logic [2:0] F3_HU   = 3'd5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic [31:0] imm;
        logic        alu_reg;
        logic        alu_imm;
        logic        load;
        logic        store;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        auipc;
        logic        wb;
    } control_info;

    function automatic control_info decode(input logic [31:0] instr);
        control_info ci;
        ci          = '0;
        ci.rd       = instr[11:7];
        ci.rs1      = instr[19:15];
        ci.rs2      = instr[24:20];
        ci.funct3   = instr[14:12];
        ci.funct7_5 = instr[30];
        unique case (instr[6:0])
            OPC_OP:     begin ci.alu_reg = 1'b1; ci.wb = 1'b1; end
            OPC_OP_IMM: begin ci.alu_imm = 1'b1; ci.wb = 1'b1; ci.imm = {{20{instr[31]}}, instr[31:20]}; end
            OPC_LOAD:   begin ci.load = 1'b1;    ci.wb = 1'b1; ci.imm = {{20{instr[31]}}, instr[31:20]}; end
            OPC_STORE:  begin ci.store = 1'b1;   ci.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
            OPC_BRANCH: begin
                ci.branch = 1'b1;
                ci.imm    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_JAL:    begin
                ci.jal = 1'b1; ci.wb = 1'b1;
                ci.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR:   begin ci.jalr = 1'b1;  ci.wb = 1'b1; ci.imm = {{20{instr[31]}}, instr[31:20]}; end
            OPC_LUI:    begin ci.lui = 1'b1;   ci.wb = 1'b1; ci.imm = {instr[31:12], 12'b0}; end
            OPC_AUIPC:  begin ci.auipc = 1'b1; ci.wb = 1'b1; ci.imm = {instr[31:12], 12'b0}; end
            default:    ;
        endcase
        return ci;
    endfunction

    // SUB only exists in the register form; SRA/SRAI both use bit 30.
    function automatic alu_op_e alu_op_of(input control_info ci);
        unique case (ci.funct3)
            F3_ADD:  return (ci.alu_reg && ci.funct7_5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ci.funct7_5 ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_dmem.sv
// Word-organised data memory: byte-enabled synchronous write, combinational read.
module rv32i_dmem #(
    parameter int WORDS = 256,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [WORDS];

    // NOTE: storage arrays carry no reset; clearing them would cost a write port per word and software never relies on it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/rv32i_decode_exec_wb.sv
// RV32I decode/execute/write-back datapath with data memory; PCs are word indices.
// Define SUBWORD_MEM_EN for byte/halfword loads and stores (otherwise all accesses are whole words).
module rv32i_decode_exec_wb
    import rv32i_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] PC,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    input  logic [31:0] RS1_VAL,
    input  logic [31:0] RS2_VAL,
    input  logic        EXEC_EN,
    output logic [31:0] JUMP_DEST,
    output logic [4:0]  RD,
    output logic        WRITE_ENABLE,
    output logic [31:0] WRITE_DATA
);
    localparam int AW = $clog2(DMEM_WORDS);

    control_info ci;
    alu_op_e     alu_op;
    logic [31:0] op_b, alu_y, imm_words, exec_result, addr;
    logic [31:0] dmem_rdata, dmem_wdata, load_data;
    logic [3:0]  dmem_be;
    logic        taken;
    logic [31:0] exec_rd_q, exec_rd_d, mem_out_q, mem_out_d;
    logic        unused_bits;

    assign ci     = decode(INSTRUCTION);
    assign alu_op = alu_op_of(ci);
    assign RS1    = ci.rs1;
    assign RS2    = ci.rs2;
    assign RD     = ci.rd;

    // NOTE: every always_comb output gets a default before the case so no latch is inferred.
    always_comb begin
        op_b  = ci.alu_reg ? RS2_VAL : ci.imm;
        alu_y = '0;
        unique case (alu_op)
            ALU_ADD:  alu_y = RS1_VAL + op_b;
            ALU_SUB:  alu_y = RS1_VAL - op_b;
            ALU_SLL:  alu_y = RS1_VAL << op_b[4:0];
            ALU_SLT:  alu_y = {31'b0, $signed(RS1_VAL) < $signed(op_b)};
            ALU_SLTU: alu_y = {31'b0, RS1_VAL < op_b};
            ALU_XOR:  alu_y = RS1_VAL ^ op_b;
            ALU_SRL:  alu_y = RS1_VAL >> op_b[4:0];
            ALU_SRA:  alu_y = $signed(RS1_VAL) >>> op_b[4:0];
            ALU_OR:   alu_y = RS1_VAL | op_b;
            default:  alu_y = RS1_VAL & op_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (ci.funct3)
            F3_BEQ:  taken = (RS1_VAL == RS2_VAL);
            F3_BNE:  taken = (RS1_VAL != RS2_VAL);
            F3_BLT:  taken = ($signed(RS1_VAL) <  $signed(RS2_VAL));
            F3_BGE:  taken = ($signed(RS1_VAL) >= $signed(RS2_VAL));
            F3_BLTU: taken = (RS1_VAL <  RS2_VAL);
            F3_BGEU: taken = (RS1_VAL >= RS2_VAL);
            default: taken = 1'b0;
        endcase
    end

    // Byte offsets from the encoding become word offsets for the word-indexed PC.
    assign imm_words = $signed(ci.imm) >>> 2;

    always_comb begin
        if (ci.jal || (ci.branch && taken)) JUMP_DEST = PC + imm_words;
        else if (ci.jalr)                   JUMP_DEST = RS1_VAL + ci.imm;
        else                                JUMP_DEST = PC + 32'd1;
    end

    always_comb begin
        if (ci.lui)                 exec_result = ci.imm;
        else if (ci.auipc)          exec_result = (PC << 2) + ci.imm;
        else if (ci.jal || ci.jalr) exec_result = PC + 32'd1;
        else                        exec_result = alu_y;
    end

    assign addr = RS1_VAL + ci.imm;

`ifdef SUBWORD_MEM_EN
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = RS2_VAL;
        load_data  = dmem_rdata;
        case (ci.funct3)
            F3_B: begin dmem_be = 4'b0001 << addr[1:0]; dmem_wdata = {4{RS2_VAL[7:0]}}; end
            F3_H: begin dmem_be = addr[1] ? 4'b1100 : 4'b0011; dmem_wdata = {2{RS2_VAL[15:0]}}; end
            default: ;
        endcase
        case (ci.funct3)
            F3_B:  load_data = {{24{dmem_rdata[8*addr[1:0] + 7]}}, dmem_rdata[8*addr[1:0] +: 8]};
            F3_BU: load_data = {24'b0, dmem_rdata[8*addr[1:0] +: 8]};
            F3_H:  load_data = {{16{dmem_rdata[16*addr[1] + 15]}}, dmem_rdata[16*addr[1] +: 16]};
            F3_HU: load_data = {16'b0, dmem_rdata[16*addr[1] +: 16]};
            default: ;
        endcase
    end
`else
    assign dmem_be    = 4'b1111;
    assign dmem_wdata = RS2_VAL;
    assign load_data  = dmem_rdata;
`endif

    rv32i_dmem #(.WORDS(DMEM_WORDS)) u_dmem (
        .clk_i   (CLK),
        .we_i    (EXEC_EN && ci.store && !RST),
        .be_i    (dmem_be),
        .addr_i  (addr[AW+1:2]),
        .wdata_i (dmem_wdata),
        .rdata_o (dmem_rdata)
    );

    assign exec_rd_d = EXEC_EN ? exec_result : exec_rd_q;
    assign mem_out_d = EXEC_EN ? load_data   : mem_out_q;

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            exec_rd_q <= '0;
            mem_out_q <= '0;
        end else begin
            exec_rd_q <= exec_rd_d;
            mem_out_q <= mem_out_d;
        end
    end

    assign WRITE_ENABLE = ci.wb && (ci.rd != 5'd0);
    assign WRITE_DATA   = ci.load ? mem_out_q : exec_rd_q;

    assign unused_bits = ^{addr[31:AW+2], addr[1:0], ci.alu_imm};

endmodule

// File: tb/tb_rv32i_decode_exec_wb.sv
// Self-checking bench: directed literal cases plus randomized instructions against a
// behavioural model that tracks the data memory contents.
module tb_rv32i_decode_exec_wb;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INSTRUCTION, PC, RS1_VAL, RS2_VAL;
    logic        EXEC_EN;
    logic [4:0]  RS1, RS2, RD;
    logic [31:0] JUMP_DEST, WRITE_DATA;
    logic        WRITE_ENABLE;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [256];

    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_ADDI = 32'h00100793;
    localparam logic [31:0] I_JAL  = 32'h074000EF;
    localparam logic [31:0] I_BLT  = 32'h00E7C663;
    localparam logic [31:0] I_SW28 = 32'h00112E23;
    localparam logic [31:0] I_LW28 = 32'h01C12083;
    localparam logic [31:0] I_SB28 = 32'h00110E23;
    localparam logic [31:0] I_LB28 = 32'h01C10083;
    localparam logic [31:0] I_LBU  = 32'h01C14083;
    localparam logic [31:0] I_SW0  = 32'h00112023;
    localparam logic [31:0] I_ADD0 = 32'h00208033;

    rv32i_decode_exec_wb #(.DMEM_WORDS(256)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .INSTRUCTION  (INSTRUCTION),
        .PC           (PC),
        .RS1          (RS1),
        .RS2          (RS2),
        .RS1_VAL      (RS1_VAL),
        .RS2_VAL      (RS2_VAL),
        .EXEC_EN      (EXEC_EN),
        .JUMP_DEST    (JUMP_DEST),
        .RD           (RD),
        .WRITE_ENABLE (WRITE_ENABLE),
        .WRITE_DATA   (WRITE_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic alt, input logic is_reg,
                                              input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: return (is_reg && alt) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Reference semantics of one instruction; also commits stores to model_mem.
    task automatic model(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] jd, output logic we,
                         output logic [31:0] wd);
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, addr, word;
        logic [2:0]  f3;
        logic        tk;
        int          widx, lane;
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        f3 = instr[14:12];
        jd = pc + 1;
        we = 1'b0;
        wd = 32'd0;
        case (instr[6:0])
            7'h33: begin we = 1'b1; wd = alu_model(f3, instr[30], 1'b1, a, b); end
            7'h13: begin we = 1'b1; wd = alu_model(f3, instr[30], 1'b0, a, imm_i); end
            7'h37: begin we = 1'b1; wd = imm_u; end
            7'h17: begin we = 1'b1; wd = pc * 4 + imm_u; end
            7'h6F: begin we = 1'b1; wd = pc + 1; jd = pc + 32'($signed(imm_j) >>> 2); end
            7'h67: begin we = 1'b1; wd = pc + 1; jd = a + imm_i; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) jd = pc + 32'($signed(imm_b) >>> 2);
            end
            7'h03: begin
                addr = a + imm_i;
                widx = int'((addr / 4) % 256);
                lane = int'(addr % 4);
                word = model_mem[widx];
                we   = 1'b1;
                wd   = word;
`ifdef SUBWORD_MEM_EN
                case (f3)
                    3'd0: wd = {{24{word[8*lane+7]}}, word[8*lane +: 8]};
                    3'd4: wd = {24'd0, word[8*lane +: 8]};
                    3'd1: wd = {{16{word[16*(lane/2)+15]}}, word[16*(lane/2) +: 16]};
                    3'd5: wd = {16'd0, word[16*(lane/2) +: 16]};
                    default: ;
                endcase
`endif
            end
            7'h23: begin
                addr = a + imm_s;
                widx = int'((addr / 4) % 256);
                lane = int'(addr % 4);
`ifdef SUBWORD_MEM_EN
                case (f3)
                    3'd0:    model_mem[widx][8*lane +: 8] = b[7:0];
                    3'd1:    model_mem[widx][16*(lane/2) +: 16] = b[15:0];
                    default: model_mem[widx] = b;
                endcase
`else
                model_mem[widx] = b;
`endif
            end
            default: ;
        endcase
        if (instr[11:7] == 5'd0) we = 1'b0;
    endtask

    // Decode/execute cycle then write cycle; outputs sampled on the falling edge of each.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_jd, exp_wd;
        logic        exp_we;
        model(instr, pc, a, b, exp_jd, exp_we, exp_wd);
        @(posedge CLK); #1;
        INSTRUCTION = instr; PC = pc; RS1_VAL = a; RS2_VAL = b; EXEC_EN = 1'b1;
        @(negedge CLK);
        check("rs1", {27'd0, RS1}, {27'd0, instr[19:15]});
        check("rs2", {27'd0, RS2}, {27'd0, instr[24:20]});
        check("rd", {27'd0, RD}, {27'd0, instr[11:7]});
        check("jump_dest", JUMP_DEST, exp_jd);
        @(posedge CLK); #1;
        EXEC_EN = 1'b0;
        @(negedge CLK);
        check("write_enable", {31'd0, WRITE_ENABLE}, {31'd0, exp_we});
        if (exp_we) check("write_data", WRITE_DATA, exp_wd);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] instr;
        logic [6:0]  opcs [11];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
        instr      = $urandom;
        instr[6:0] = opcs[$urandom_range(0, 10)];
        if (instr[6:0] == 7'h33) begin
            instr[31]    = 1'b0;
            instr[29:25] = 5'd0;
        end
        return instr;
    endfunction

    initial begin
        logic [31:0] a, b;
        RST = 1'b1; EXEC_EN = 1'b0; INSTRUCTION = I_NOP; PC = '0; RS1_VAL = '0; RS2_VAL = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("reset_exec_rd", WRITE_DATA, 32'd0);
        INSTRUCTION = I_LW28;
        #1 check("reset_mem_out", WRITE_DATA, 32'd0);

        for (int i = 0; i < 256; i++) run_instr(I_SW0, 32'(i), 32'(i * 4), $urandom);

        run_instr(I_ADDI, 32'd8, 32'd0, 32'd0);
        check("lit_addi_rs1", {27'd0, RS1}, 32'd0);
        check("lit_addi_rd", {27'd0, RD}, 32'd15);
        check("lit_addi_jd", JUMP_DEST, 32'd9);
        check("lit_addi_we", {31'd0, WRITE_ENABLE}, 32'd1);
        check("lit_addi_wd", WRITE_DATA, 32'd1);

        run_instr(I_JAL, 32'd0, 32'd0, 32'd0);
        check("lit_jal_jd", JUMP_DEST, 32'd29);
        check("lit_jal_rd", {27'd0, RD}, 32'd1);
        check("lit_jal_wd", WRITE_DATA, 32'd1);

        run_instr(I_BLT, 32'd9, 32'd1, 32'd3);
        check("lit_blt_taken_jd", JUMP_DEST, 32'd12);
        run_instr(I_BLT, 32'd9, 32'd1, 32'd1);
        check("lit_blt_not_taken_jd", JUMP_DEST, 32'd10);
        check("lit_blt_we", {31'd0, WRITE_ENABLE}, 32'd0);

        run_instr(I_SW28, 32'd20, 32'd480, 32'd35);
        run_instr(I_LW28, 32'd21, 32'd480, 32'd0);
        check("lit_lw_wd", WRITE_DATA, 32'd35);
`ifdef SUBWORD_MEM_EN
        run_instr(I_SB28, 32'd22, 32'd480, 32'h80);
        run_instr(I_LB28, 32'd23, 32'd480, 32'd0);
        check("lit_lb_wd", WRITE_DATA, 32'hFFFFFF80);
        run_instr(I_LBU, 32'd24, 32'd480, 32'd0);
        check("lit_lbu_wd", WRITE_DATA, 32'h00000080);
`endif

        run_instr(I_ADD0, 32'd30, 32'd5, 32'd6);
        check("lit_add_x0_we", {31'd0, WRITE_ENABLE}, 32'd0);

        // Store attempted in a reset cycle must leave memory untouched.
        @(posedge CLK); #1;
        INSTRUCTION = I_SW28; PC = 32'd31; RS1_VAL = 32'd480; RS2_VAL = 32'hDEADBEEF;
        EXEC_EN = 1'b1; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; EXEC_EN = 1'b0;
        @(negedge CLK);
        check("rst_store_wd", WRITE_DATA, 32'd0);
        check("rst_store_we", {31'd0, WRITE_ENABLE}, 32'd0);
        run_instr(I_LW28, 32'd32, 32'd480, 32'd0);
`ifdef SUBWORD_MEM_EN
        check("rst_store_mem", WRITE_DATA, 32'h00000080);
`else
        check("rst_store_mem", WRITE_DATA, 32'd35);
`endif

        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(rand_instr(), $urandom, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
